// File: rtl/aes_top_if.sv
// Start/plaintext/key request bundle and ciphertext response for the AES-128 core.
// Master drives the request; slave (the core) returns ciphertext plus a one-cycle valid.
interface aes_top_if;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;

  modport master (
    output AES_en, AES_data_in, AES_key_in,
    input  AES_data_out, AES_data_out_valid
  );

  modport slave (
    input  AES_en, AES_data_in, AES_key_in,
    output AES_data_out, AES_data_out_valid
  );
endinterface

// File: rtl/aes_top.sv
// Iterative AES-128 encrypt, one round per clock with on-the-fly key expansion; start to valid is 10 cycles.
// No backpressure: inputs are ignored while busy, the ciphertext is held and flagged by a one-cycle valid pulse.
module aes_top (
  input  logic      AES_clk,
  input  logic      AES_rst_n,
  aes_top_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] dout_q, dout_d;
  logic         vld_q, vld_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128 (zero maps to zero), then the affine step.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] inv;
    t   = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t   = gf_mul(t, t);
      inv = gf_mul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [127:0] sb, sr, mc, rk_nxt, rnd_out;
  logic [31:0]  kw0, kw1, kw2, kw3;
  logic         last_rnd;

  always_comb begin
    sb = '0;
    for (int i = 0; i < 16; i++) sb[8*i +: 8] = sbox(blk_q[8*i +: 8]);
    sr = shift_rows(sb);
    mc = '0;
    for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    kw0 = rk_q[127:96] ^ sub_word({rk_q[23:0], rk_q[31:24]}) ^ {rcon(rnd_q), 24'h0};
    kw1 = rk_q[95:64] ^ kw0;
    kw2 = rk_q[63:32] ^ kw1;
    kw3 = rk_q[31:0]  ^ kw2;
    rk_nxt   = {kw0, kw1, kw2, kw3};
    last_rnd = (rnd_q == 4'd10);
    rnd_out  = (last_rnd ? sr : mc) ^ rk_nxt;
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      fsm_q  <= IDLE;
      blk_q  <= '0;
      rk_q   <= '0;
      rnd_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      rk_q   <= rk_d;
      rnd_q  <= rnd_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (bus.AES_en) fsm_d = BUSY;
      BUSY:    if (last_rnd) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    blk_d  = blk_q;
    rk_d   = rk_q;
    rnd_d  = rnd_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (bus.AES_en) begin
          blk_d = bus.AES_data_in ^ bus.AES_key_in;
          rk_d  = bus.AES_key_in;
          rnd_d = 4'd1;
        end
      end
      BUSY: begin
        blk_d = rnd_out;
        rk_d  = rk_nxt;
        rnd_d = rnd_q + 4'd1;
        if (last_rnd) begin
          dout_d = rnd_out;
          vld_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.AES_data_out       = dout_q;
  assign bus.AES_data_out_valid = vld_q;
endmodule

// File: tb/tb_aes_top.sv
// Bench for aes_top: known-answer vectors plus random blocks checked against a byte-array AES model.
module tb_aes_top;
  logic AES_clk;
  logic AES_rst_n;
  aes_top_if bus ();

  aes_top dut (
    .AES_clk   (AES_clk),
    .AES_rst_n (AES_rst_n),
    .bus       (bus)
  );

  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  int checks = 0;
  int errs   = 0;
  logic [7:0] sbox_tbl [256];

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] y;
    y = {x, x} << n;
    return y[15:8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table from the generator-3 walk: p steps by *3, q tracks its inverse.
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    for (int k = 0; k < 255; k++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sbox_tbl[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end
    sbox_tbl[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tbl[tmp[23:16]], sbox_tbl[tmp[15:8]], sbox_tbl[tmp[7:0]], sbox_tbl[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) t[j] = sbox_tbl[s[j]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    o = '0;
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge AES_clk);
    @(negedge AES_clk);
  endtask

  // One-cycle start pulse; expects valid exactly 10 edges after the start edge.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input string tag);
    int lat;
    lat = 0;
    bus.AES_data_in = pt;
    bus.AES_key_in  = key;
    bus.AES_en      = 1'b1;
    tick();
    bus.AES_en = 1'b0;
    for (int i = 1; i <= 15 && lat == 0; i++) begin
      tick();
      if (bus.AES_data_out_valid === 1'b1) lat = i;
    end
    check({tag, " latency"}, 128'(lat), 128'd10);
    check({tag, " ct"}, bus.AES_data_out, exp);
    tick();
    check({tag, " pulse_end"}, 128'(bus.AES_data_out_valid), 128'd0);
    check({tag, " hold"}, bus.AES_data_out, exp);
  endtask

  initial begin
    logic [127:0] pt, key, exp;
    int first, pulses, n_exp, seen;

    build_sbox();
    AES_rst_n       = 1'b0;
    bus.AES_en      = 1'b1;
    bus.AES_data_in = rand128();
    bus.AES_key_in  = rand128();

    // Reset held with start requested: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst out", bus.AES_data_out, 128'd0);
      check("rst valid", 128'(bus.AES_data_out_valid), 128'd0);
    end
    exp = aes_ref(bus.AES_data_in, bus.AES_key_in);
    AES_rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      tick();
      if (bus.AES_data_out_valid === 1'b1) first = i;
    end
    bus.AES_en = 1'b0;
    check("post_rst first_valid", 128'(first), 128'd11);
    check("post_rst ct", bus.AES_data_out, exp);
    tick();

    run_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3925841d02dc09fbdc118597196a0b32, "fips_b");
    run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips_c1");
    run_block(128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, "zero");

    for (int k = 0; k < 4; k++) begin
      pt  = rand128();
      key = rand128();
      run_block(pt, key, aes_ref(pt, key), "random");
    end

    // Level-held start: one block per 11 cycles, all identical.
    pt  = rand128();
    key = rand128();
    exp = aes_ref(pt, key);
    bus.AES_data_in = pt;
    bus.AES_key_in  = key;
    pulses = 0;
    n_exp  = (51 - 1) / 11 + 1;
    for (int t = 1; t <= 70; t++) begin
      bus.AES_en = (t <= 51);
      tick();
      if (bus.AES_data_out_valid === 1'b1) begin
        pulses++;
        check("held spacing", 128'(t), 128'(11 * pulses));
        check("held ct", bus.AES_data_out, exp);
      end
    end
    check("held pulses", 128'(pulses), 128'(n_exp));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("after_fall valid", 128'(bus.AES_data_out_valid), 128'd0);
      check("after_fall hold", bus.AES_data_out, exp);
    end

    // Inputs churn every cycle while busy; result follows the captured inputs.
    pt  = rand128();
    key = rand128();
    exp = aes_ref(pt, key);
    bus.AES_data_in = pt;
    bus.AES_key_in  = key;
    bus.AES_en      = 1'b1;
    tick();
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      bus.AES_data_in = rand128();
      bus.AES_key_in  = rand128();
      bus.AES_en      = 1'($urandom_range(0, 1));
      tick();
      if (bus.AES_data_out_valid === 1'b1 && first == 0) first = i;
    end
    bus.AES_en = 1'b0;
    check("churn latency", 128'(first), 128'd10);
    check("churn ct", bus.AES_data_out, exp);
    tick();
    check("churn pulse_end", 128'(bus.AES_data_out_valid), 128'd0);

    // Reset during round 5 aborts the block.
    pt  = rand128();
    key = rand128();
    bus.AES_data_in = pt;
    bus.AES_key_in  = key;
    bus.AES_en      = 1'b1;
    tick();
    bus.AES_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    AES_rst_n = 1'b0;
    #1;
    check("abort out", bus.AES_data_out, 128'd0);
    check("abort valid", 128'(bus.AES_data_out_valid), 128'd0);
    tick();
    tick();
    AES_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.AES_data_out_valid !== 1'b0) seen++;
    end
    check("abort no_valid", 128'(seen), 128'd0);
    check("abort out_zero", bus.AES_data_out, 128'd0);
    pt  = rand128();
    key = rand128();
    run_block(pt, key, aes_ref(pt, key), "after_abort");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
